// File: rtl/rominit_ctrl.sv
// rominit_ctrl: steers the ioctl download stream into the boot, character,
// APU and cartridge ROM write ports. It holds the core in reset while ROMs
// load and for a settling window afterwards, and reports BIOS completeness,
// BIOS overflow and the size of the last cartridge.
//
// Handshake: there is no back-pressure. Every IOCTL_WR pulse accepted in a
// LOAD_* state produces exactly one ROMINIT_VALID pulse on the next cycle,
// unless it falls outside the BIOS regions. Strobes may arrive on every cycle.
module rominit_ctrl #(
  parameter int BOOT_BYTES  = 4096,
  parameter int CHR_BYTES   = 1024,
  parameter int APU_BYTES   = 1024,
  parameter int HOLD_CYCLES = 64
) (
  input  logic        CLK,
  input  logic        RES,
  input  logic        IOCTL_DOWNLOAD,
  input  logic [7:0]  IOCTL_INDEX,
  input  logic        IOCTL_WR,
  input  logic [24:0] IOCTL_ADDR,
  input  logic [7:0]  IOCTL_DOUT,
  output logic        ROMINIT_SEL_BOOT,
  output logic        ROMINIT_SEL_CHR,
  output logic        ROMINIT_SEL_APU,
  output logic        ROMINIT_SEL_CART,
  output logic [24:0] ROMINIT_ADDR,
  output logic [7:0]  ROMINIT_DATA,
  output logic        ROMINIT_VALID,
  output logic        CORE_RES,
  output logic        BIOS_LOADED,
  output logic [24:0] CART_SIZE,
  output logic        BIOS_OVF,
  output logic [2:0]  DBG_STATE
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD_BIOS = 3'd1,
    LOAD_CART = 3'd2,
    HOLD      = 3'd3,
    RUN       = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    RG_BOOT = 2'd0,
    RG_CHR  = 2'd1,
    RG_APU  = 2'd2,
    RG_NONE = 2'd3
  } region_t;

  // Region boundaries inside the BIOS stream.
  localparam logic [24:0] CHR_BASE  = 25'(BOOT_BYTES);
  localparam logic [24:0] APU_BASE  = 25'(BOOT_BYTES + CHR_BYTES);
  localparam logic [24:0] BIOS_END  = 25'(BOOT_BYTES + CHR_BYTES + APU_BYTES);
  localparam logic [24:0] BIOS_LAST = BIOS_END - 25'd1;

  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

  state_t        state;
  state_t        next_state;
  region_t       region_q;
  region_t       region_d;
  region_t       wr_region;
  logic [24:0]   wr_offset;
  logic [HW-1:0] hold_cnt;

  logic          dl_q;
  logic          dl_rise;
  logic          idx_bios;
  logic          idx_cart;
  logic          bios_wr;
  logic          cart_wr;
  logic          bios_start;
  logic          cart_start;
  logic          bios_end;
  logic          cart_end;
  logic          bios_sel_on;
  logic          last_hit;
  logic          last_seen;
  logic          cart_any;
  logic [24:0]   cart_hi;
  logic          cart_any_d;
  logic [24:0]   cart_hi_d;

  assign DBG_STATE  = state;

  // A rising edge needs the download line seen low first; the history flop
  // resets high so a download already in progress at reset release is not
  // mistaken for a new one.
  assign dl_rise    = IOCTL_DOWNLOAD & ~dl_q;
  assign idx_bios   = (IOCTL_INDEX == 8'd0);
  assign idx_cart   = (IOCTL_INDEX == 8'd1);
  assign bios_wr    = (state == LOAD_BIOS) && IOCTL_WR;
  assign cart_wr    = (state == LOAD_CART) && IOCTL_WR;
  assign bios_start = (next_state == LOAD_BIOS) && (state != LOAD_BIOS);
  assign cart_start = (next_state == LOAD_CART) && (state != LOAD_CART);
  assign bios_end   = (state == LOAD_BIOS) && !IOCTL_DOWNLOAD;
  assign cart_end   = (state == LOAD_CART) && !IOCTL_DOWNLOAD;
  assign last_hit   = bios_wr && (IOCTL_ADDR == BIOS_LAST);
  // Selects stay on for the whole load and also cover a byte strobed in the
  // very cycle the download line drops.
  assign bios_sel_on = (next_state == LOAD_BIOS) || bios_wr;

  // Download-line edge history.
  always_ff @(posedge CLK or posedge RES) begin
    if (RES) dl_q <= 1'b1;
    else     dl_q <= IOCTL_DOWNLOAD;
  end

  // State register.
  always_ff @(posedge CLK or posedge RES) begin
    if (RES) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state logic: new downloads pre-empt HOLD and RUN; HOLD exits to
  // RUN only when a complete BIOS is present.
  always_comb begin
    next_state = state;
    case (state)
      IDLE, HOLD, RUN: begin
        if (dl_rise && idx_bios) begin
          next_state = LOAD_BIOS;
        end else if (dl_rise && idx_cart) begin
          next_state = LOAD_CART;
        end else if ((state == HOLD) && (hold_cnt == HOLD_LAST)) begin
          next_state = BIOS_LOADED ? RUN : IDLE;
        end
      end
      LOAD_BIOS, LOAD_CART: begin
        if (!IOCTL_DOWNLOAD) next_state = HOLD;
      end
      default: next_state = IDLE;
    endcase
  end

  // Hold counter: runs only while staying in HOLD, restarts on every entry.
  always_ff @(posedge CLK or posedge RES) begin
    if (RES)                                        hold_cnt <= '0;
    else if ((state == HOLD) && (next_state == HOLD)) hold_cnt <= hold_cnt + 1'b1;
    else                                            hold_cnt <= '0;
  end

  // BIOS address decode into region and region-relative offset.
  always_comb begin
    wr_region = RG_NONE;
    wr_offset = '0;
    if (IOCTL_ADDR < CHR_BASE) begin
      wr_region = RG_BOOT;
      wr_offset = IOCTL_ADDR;
    end else if (IOCTL_ADDR < APU_BASE) begin
      wr_region = RG_CHR;
      wr_offset = IOCTL_ADDR - CHR_BASE;
    end else if (IOCTL_ADDR < BIOS_END) begin
      wr_region = RG_APU;
      wr_offset = IOCTL_ADDR - APU_BASE;
    end
  end

  // Region shown on the selects: follows the latest BIOS byte, boot at start.
  always_comb begin
    region_d = region_q;
    if (bios_wr)         region_d = wr_region;
    else if (bios_start) region_d = RG_BOOT;
  end

  // Current BIOS region register.
  always_ff @(posedge CLK or posedge RES) begin
    if (RES) region_q <= RG_BOOT;
    else     region_q <= region_d;
  end

  // Registered ROM write port; address and data hold when nothing is written.
  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      ROMINIT_VALID    <= 1'b0;
      ROMINIT_ADDR     <= '0;
      ROMINIT_DATA     <= '0;
      ROMINIT_SEL_BOOT <= 1'b0;
      ROMINIT_SEL_CHR  <= 1'b0;
      ROMINIT_SEL_APU  <= 1'b0;
      ROMINIT_SEL_CART <= 1'b0;
    end else begin
      ROMINIT_VALID    <= (bios_wr && (wr_region != RG_NONE)) || cart_wr;
      ROMINIT_SEL_BOOT <= bios_sel_on && (region_d == RG_BOOT);
      ROMINIT_SEL_CHR  <= bios_sel_on && (region_d == RG_CHR);
      ROMINIT_SEL_APU  <= bios_sel_on && (region_d == RG_APU);
      ROMINIT_SEL_CART <= (next_state == LOAD_CART) || cart_wr;
      if (bios_wr && (wr_region != RG_NONE)) begin
        ROMINIT_ADDR <= wr_offset;
        ROMINIT_DATA <= IOCTL_DOUT;
      end else if (cart_wr) begin
        ROMINIT_ADDR <= IOCTL_ADDR;
        ROMINIT_DATA <= IOCTL_DOUT;
      end
    end
  end

  // Core reset: released only while running.
  always_ff @(posedge CLK or posedge RES) begin
    if (RES) CORE_RES <= 1'b1;
    else     CORE_RES <= (next_state != RUN);
  end

  // BIOS status: completeness requires the final byte; overflow is sticky.
  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      BIOS_LOADED <= 1'b0;
      BIOS_OVF    <= 1'b0;
      last_seen   <= 1'b0;
    end else if (bios_start) begin
      BIOS_LOADED <= 1'b0;
      BIOS_OVF    <= 1'b0;
      last_seen   <= 1'b0;
    end else begin
      if (bios_wr && (wr_region == RG_NONE)) BIOS_OVF <= 1'b1;
      if (last_hit) last_seen <= 1'b1;
      if (bios_end) BIOS_LOADED <= last_seen | last_hit;
    end
  end

  // Highest cart address including a strobe in the current cycle.
  always_comb begin
    cart_any_d = cart_any;
    cart_hi_d  = cart_hi;
    if (cart_wr && (!cart_any || (IOCTL_ADDR > cart_hi))) begin
      cart_any_d = 1'b1;
      cart_hi_d  = IOCTL_ADDR;
    end
  end

  // Cart size tracking, published when the cart download ends.
  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      CART_SIZE <= '0;
      cart_any  <= 1'b0;
      cart_hi   <= '0;
    end else if (cart_start) begin
      CART_SIZE <= '0;
      cart_any  <= 1'b0;
      cart_hi   <= '0;
    end else begin
      cart_any <= cart_any_d;
      cart_hi  <= cart_hi_d;
      if (cart_end) CART_SIZE <= cart_any_d ? (cart_hi_d + 25'd1) : 25'd0;
    end
  end

endmodule

// File: tb/tb_rominit_ctrl.sv
// Bench for rominit_ctrl: file downloads with a write scoreboard.
`timescale 1ns/1ps
module tb_rominit_ctrl;

  localparam int BOOT  = 4096;
  localparam int CHR   = 1024;
  localparam int APU   = 1024;
  localparam int HOLDC = 64;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_LOAD_BIOS = 3'd1;
  localparam logic [2:0] ST_LOAD_CART = 3'd2;
  localparam logic [2:0] ST_HOLD      = 3'd3;
  localparam logic [2:0] ST_RUN       = 3'd4;

  logic        CLK;
  logic        RES;
  logic        IOCTL_DOWNLOAD;
  logic [7:0]  IOCTL_INDEX;
  logic        IOCTL_WR;
  logic [24:0] IOCTL_ADDR;
  logic [7:0]  IOCTL_DOUT;
  logic        ROMINIT_SEL_BOOT;
  logic        ROMINIT_SEL_CHR;
  logic        ROMINIT_SEL_APU;
  logic        ROMINIT_SEL_CART;
  logic [24:0] ROMINIT_ADDR;
  logic [7:0]  ROMINIT_DATA;
  logic        ROMINIT_VALID;
  logic        CORE_RES;
  logic        BIOS_LOADED;
  logic [24:0] CART_SIZE;
  logic        BIOS_OVF;
  logic [2:0]  DBG_STATE;

  int total = 0;
  int bad = 0;
  int valid_seen = 0;
  logic [36:0] exp_q[$];
  logic [36:0] mon_obs;
  logic [36:0] mon_exp;

  rominit_ctrl dut (
    .CLK(CLK), .RES(RES), .IOCTL_DOWNLOAD(IOCTL_DOWNLOAD), .IOCTL_INDEX(IOCTL_INDEX),
    .IOCTL_WR(IOCTL_WR), .IOCTL_ADDR(IOCTL_ADDR), .IOCTL_DOUT(IOCTL_DOUT),
    .ROMINIT_SEL_BOOT(ROMINIT_SEL_BOOT), .ROMINIT_SEL_CHR(ROMINIT_SEL_CHR),
    .ROMINIT_SEL_APU(ROMINIT_SEL_APU), .ROMINIT_SEL_CART(ROMINIT_SEL_CART),
    .ROMINIT_ADDR(ROMINIT_ADDR), .ROMINIT_DATA(ROMINIT_DATA), .ROMINIT_VALID(ROMINIT_VALID),
    .CORE_RES(CORE_RES), .BIOS_LOADED(BIOS_LOADED), .CART_SIZE(CART_SIZE),
    .BIOS_OVF(BIOS_OVF), .DBG_STATE(DBG_STATE)
  );

  // Clock and time limit
  initial begin
    CLK = 1'b0;
    forever #17 CLK = ~CLK;
  end

  initial begin
    #20ms;
    bad++;
    $display("FAIL watchdog got=timeout want=finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Scoreboard: every VALID pops one expected {selects, addr, data}
  always @(negedge CLK) begin
    if (ROMINIT_VALID === 1'b1) begin
      mon_obs = {ROMINIT_SEL_BOOT, ROMINIT_SEL_CHR, ROMINIT_SEL_APU, ROMINIT_SEL_CART,
                 ROMINIT_ADDR, ROMINIT_DATA};
      valid_seen++;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_valid got=%h want=none", mon_obs);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_obs !== mon_exp) begin
          bad++;
          $display("FAIL rominit_write got=%h want=%h", mon_obs, mon_exp);
        end
      end
    end
  end

  // Driver tasks
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic start_dl(input logic [7:0] idx);
    IOCTL_INDEX    = idx;
    IOCTL_DOWNLOAD = 1'b1;
    tick();
    tick();
  endtask

  task automatic send_bytes(input logic [7:0] idx, input int n, input bit gaps);
    for (int a = 0; a < n; a++) begin
      if (gaps && ($urandom_range(0, 7) == 0)) begin
        IOCTL_WR = 1'b0;
        tick();
      end
      IOCTL_WR   = 1'b1;
      IOCTL_ADDR = 25'(a);
      IOCTL_DOUT = 8'(a);
      if (idx == 8'd0) begin
        if (a < BOOT)                  exp_q.push_back({4'b1000, 25'(a), 8'(a)});
        else if (a < BOOT + CHR)       exp_q.push_back({4'b0100, 25'(a - BOOT), 8'(a)});
        else if (a < BOOT + CHR + APU) exp_q.push_back({4'b0010, 25'(a - BOOT - CHR), 8'(a)});
      end else if (idx == 8'd1) begin
        exp_q.push_back({4'b0001, 25'(a), 8'(a)});
      end
      tick();
    end
    IOCTL_WR = 1'b0;
  endtask

  // Drops the download line and counts cycles until the core is released.
  task automatic measure_hold(output int n);
    IOCTL_DOWNLOAD = 1'b0;
    tick();
    n = 0;
    while ((CORE_RES !== 1'b0) && (n < 200)) begin
      tick();
      n++;
    end
  endtask

  // Scenarios
  task automatic test_reset();
    RES = 1'b1;
    tick();
    tick();
    total++; if (DBG_STATE !== ST_IDLE) begin bad++; $display("FAIL reset_state got=%0d want=%0d", DBG_STATE, ST_IDLE); end
    total++; if (CORE_RES !== 1'b1) begin bad++; $display("FAIL reset_core_res got=%b want=1", CORE_RES); end
    total++; if ({ROMINIT_SEL_BOOT, ROMINIT_SEL_CHR, ROMINIT_SEL_APU, ROMINIT_SEL_CART, ROMINIT_VALID} !== 5'b0) begin
      bad++; $display("FAIL reset_sel_valid got=%b want=00000", {ROMINIT_SEL_BOOT, ROMINIT_SEL_CHR, ROMINIT_SEL_APU, ROMINIT_SEL_CART, ROMINIT_VALID}); end
    total++; if ({ROMINIT_ADDR, ROMINIT_DATA} !== 33'd0) begin bad++; $display("FAIL reset_addr_data got=%h want=0", {ROMINIT_ADDR, ROMINIT_DATA}); end
    total++; if ({BIOS_LOADED, BIOS_OVF, CART_SIZE} !== 27'd0) begin bad++; $display("FAIL reset_status got=%h want=0", {BIOS_LOADED, BIOS_OVF, CART_SIZE}); end
    RES = 1'b0;
    tick();
  endtask

  task automatic test_full_bios();
    int n;
    valid_seen = 0;
    start_dl(8'd0);
    total++; if (DBG_STATE !== ST_LOAD_BIOS) begin bad++; $display("FAIL full_enter got=%0d want=%0d", DBG_STATE, ST_LOAD_BIOS); end
    total++; if (ROMINIT_SEL_BOOT !== 1'b1) begin bad++; $display("FAIL full_sel_boot_early got=%b want=1", ROMINIT_SEL_BOOT); end
    send_bytes(8'd0, BOOT + CHR + APU, 1'b1);
    tick();
    total++; if ({ROMINIT_SEL_APU, ROMINIT_VALID} !== 2'b10) begin bad++; $display("FAIL full_sel_hold got=%b want=10", {ROMINIT_SEL_APU, ROMINIT_VALID}); end
    total++; if ({ROMINIT_ADDR, ROMINIT_DATA} !== {25'd1023, 8'hFF}) begin bad++; $display("FAIL full_addr_hold got=%h want=%h", {ROMINIT_ADDR, ROMINIT_DATA}, {25'd1023, 8'hFF}); end
    measure_hold(n);
    total++; if (n !== HOLDC) begin bad++; $display("FAIL full_hold_len got=%0d want=%0d", n, HOLDC); end
    total++; if (BIOS_LOADED !== 1'b1) begin bad++; $display("FAIL full_loaded got=%b want=1", BIOS_LOADED); end
    total++; if (BIOS_OVF !== 1'b0) begin bad++; $display("FAIL full_ovf got=%b want=0", BIOS_OVF); end
    total++; if (DBG_STATE !== ST_RUN) begin bad++; $display("FAIL full_run got=%0d want=%0d", DBG_STATE, ST_RUN); end
    total++; if ({ROMINIT_SEL_BOOT, ROMINIT_SEL_CHR, ROMINIT_SEL_APU, ROMINIT_SEL_CART} !== 4'b0) begin bad++; $display("FAIL full_sel_run got=%b want=0000", {ROMINIT_SEL_BOOT, ROMINIT_SEL_CHR, ROMINIT_SEL_APU, ROMINIT_SEL_CART}); end
    total++; if (valid_seen !== 6144) begin bad++; $display("FAIL full_count got=%0d want=6144", valid_seen); end
    total++; if (exp_q.size() !== 0) begin bad++; $display("FAIL full_leftover got=%0d want=0", exp_q.size()); end
  endtask

  task automatic test_short_bios();
    int lows = 0;
    valid_seen = 0;
    start_dl(8'd0);
    total++; if (BIOS_LOADED !== 1'b0) begin bad++; $display("FAIL short_clear got=%b want=0", BIOS_LOADED); end
    send_bytes(8'd0, 5000, 1'b0);
    tick();
    IOCTL_DOWNLOAD = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (CORE_RES !== 1'b1) lows++;
    end
    total++; if (lows !== 0) begin bad++; $display("FAIL short_core_res got=%0d want=0", lows); end
    total++; if (BIOS_LOADED !== 1'b0) begin bad++; $display("FAIL short_loaded got=%b want=0", BIOS_LOADED); end
    total++; if (DBG_STATE !== ST_IDLE) begin bad++; $display("FAIL short_idle got=%0d want=%0d", DBG_STATE, ST_IDLE); end
    total++; if (valid_seen !== 5000) begin bad++; $display("FAIL short_count got=%0d want=5000", valid_seen); end
  endtask

  task automatic test_overflow();
    int n;
    valid_seen = 0;
    start_dl(8'd0);
    send_bytes(8'd0, 6200, 1'b0);
    tick();
    total++; if (BIOS_OVF !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%b want=1", BIOS_OVF); end
    total++; if ({ROMINIT_ADDR, ROMINIT_DATA} !== {25'd1023, 8'hFF}) begin bad++; $display("FAIL ovf_addr_hold got=%h want=%h", {ROMINIT_ADDR, ROMINIT_DATA}, {25'd1023, 8'hFF}); end
    measure_hold(n);
    total++; if (n !== HOLDC) begin bad++; $display("FAIL ovf_hold_len got=%0d want=%0d", n, HOLDC); end
    total++; if ({BIOS_LOADED, BIOS_OVF} !== 2'b11) begin bad++; $display("FAIL ovf_status got=%b want=11", {BIOS_LOADED, BIOS_OVF}); end
    total++; if (valid_seen !== 6144) begin bad++; $display("FAIL ovf_count got=%0d want=6144", valid_seen); end
  endtask

  task automatic test_cart();
    int n;
    valid_seen = 0;
    start_dl(8'd1);
    total++; if ({DBG_STATE, ROMINIT_SEL_CART, CORE_RES} !== {ST_LOAD_CART, 2'b11}) begin
      bad++; $display("FAIL cart_enter got=%b want=%b", {DBG_STATE, ROMINIT_SEL_CART, CORE_RES}, {ST_LOAD_CART, 2'b11}); end
    send_bytes(8'd1, 32768, 1'b0);
    tick();
    total++; if (CORE_RES !== 1'b1) begin bad++; $display("FAIL cart_core_res_load got=%b want=1", CORE_RES); end
    measure_hold(n);
    total++; if (n !== HOLDC) begin bad++; $display("FAIL cart_hold_len got=%0d want=%0d", n, HOLDC); end
    total++; if (CART_SIZE !== 25'd32768) begin bad++; $display("FAIL cart_size got=%0d want=32768", CART_SIZE); end
    total++; if (DBG_STATE !== ST_RUN) begin bad++; $display("FAIL cart_run got=%0d want=%0d", DBG_STATE, ST_RUN); end
    total++; if (valid_seen !== 32768) begin bad++; $display("FAIL cart_count got=%0d want=32768", valid_seen); end
  endtask

  task automatic test_restart_hold();
    int n;
    int lows = 0;
    start_dl(8'd1);
    send_bytes(8'd1, 100, 1'b1);
    tick();
    IOCTL_DOWNLOAD = 1'b0;
    tick();
    for (int i = 0; i < 10; i++) begin
      tick();
      if (CORE_RES !== 1'b1) lows++;
    end
    total++; if (DBG_STATE !== ST_HOLD) begin bad++; $display("FAIL restart_in_hold got=%0d want=%0d", DBG_STATE, ST_HOLD); end
    total++; if (CART_SIZE !== 25'd100) begin bad++; $display("FAIL restart_size1 got=%0d want=100", CART_SIZE); end
    start_dl(8'd1);
    if (CORE_RES !== 1'b1) lows++;
    total++; if (DBG_STATE !== ST_LOAD_CART) begin bad++; $display("FAIL restart_reenter got=%0d want=%0d", DBG_STATE, ST_LOAD_CART); end
    total++; if (CART_SIZE !== 25'd0) begin bad++; $display("FAIL restart_size_clear got=%0d want=0", CART_SIZE); end
    send_bytes(8'd1, 200, 1'b1);
    tick();
    measure_hold(n);
    total++; if (lows !== 0) begin bad++; $display("FAIL restart_core_res got=%0d want=0", lows); end
    total++; if (n !== HOLDC) begin bad++; $display("FAIL restart_hold_len got=%0d want=%0d", n, HOLDC); end
    total++; if (CART_SIZE !== 25'd200) begin bad++; $display("FAIL restart_size2 got=%0d want=200", CART_SIZE); end
  endtask

  task automatic test_ignored_index();
    valid_seen = 0;
    send_bytes(8'd2, 8, 1'b0);
    start_dl(8'd2);
    send_bytes(8'd2, 20, 1'b0);
    tick();
    total++; if ({DBG_STATE, CORE_RES} !== {ST_RUN, 1'b0}) begin bad++; $display("FAIL ignored_state got=%b want=%b", {DBG_STATE, CORE_RES}, {ST_RUN, 1'b0}); end
    IOCTL_DOWNLOAD = 1'b0;
    tick();
    total++; if (valid_seen !== 0) begin bad++; $display("FAIL ignored_writes got=%0d want=0", valid_seen); end
  endtask

  task automatic test_reset_mid();
    valid_seen = 0;
    start_dl(8'd0);
    send_bytes(8'd0, 2000, 1'b0);
    @(negedge CLK);
    #2;
    RES = 1'b1;
    #1;
    total++; if (valid_seen !== 2000) begin bad++; $display("FAIL mid_count got=%0d want=2000", valid_seen); end
    total++; if ({ROMINIT_SEL_BOOT, ROMINIT_SEL_CHR, ROMINIT_SEL_APU, ROMINIT_SEL_CART, ROMINIT_VALID} !== 5'b0) begin
      bad++; $display("FAIL mid_sel_valid got=%b want=00000", {ROMINIT_SEL_BOOT, ROMINIT_SEL_CHR, ROMINIT_SEL_APU, ROMINIT_SEL_CART, ROMINIT_VALID}); end
    total++; if ({ROMINIT_ADDR, ROMINIT_DATA} !== 33'd0) begin bad++; $display("FAIL mid_addr_data got=%h want=0", {ROMINIT_ADDR, ROMINIT_DATA}); end
    total++; if ({BIOS_LOADED, BIOS_OVF, CART_SIZE} !== 27'd0) begin bad++; $display("FAIL mid_status got=%h want=0", {BIOS_LOADED, BIOS_OVF, CART_SIZE}); end
    total++; if ({DBG_STATE, CORE_RES} !== {ST_IDLE, 1'b1}) begin bad++; $display("FAIL mid_state got=%b want=%b", {DBG_STATE, CORE_RES}, {ST_IDLE, 1'b1}); end
    tick();
    tick();
    RES = 1'b0;
    send_bytes(8'd2, 30, 1'b0);
    tick();
    total++; if (DBG_STATE !== ST_IDLE) begin bad++; $display("FAIL mid_no_restart got=%0d want=%0d", DBG_STATE, ST_IDLE); end
    total++; if (valid_seen !== 2000) begin bad++; $display("FAIL mid_no_valid got=%0d want=2000", valid_seen); end
    IOCTL_DOWNLOAD = 1'b0;
    tick();
    start_dl(8'd0);
    send_bytes(8'd0, 10, 1'b0);
    tick();
    total++; if (valid_seen !== 2010) begin bad++; $display("FAIL mid_new_load got=%0d want=2010", valid_seen); end
    total++; if (exp_q.size() !== 0) begin bad++; $display("FAIL mid_leftover got=%0d want=0", exp_q.size()); end
    IOCTL_DOWNLOAD = 1'b0;
    repeat (4) tick();
  endtask

  // Sequence and report
  initial begin
    RES            = 1'b1;
    IOCTL_DOWNLOAD = 1'b0;
    IOCTL_INDEX    = 8'd0;
    IOCTL_WR       = 1'b0;
    IOCTL_ADDR     = '0;
    IOCTL_DOUT     = '0;
    test_reset();
    test_full_bios();
    test_short_bios();
    test_overflow();
    test_cart();
    test_restart_hold();
    test_ignored_index();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
